// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, constants and types for the FPU datapath.
package fpu_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } float_t;

   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } spec_t;

endpackage

// File: rtl/fmul_mant_mul.sv
// 24x24 unsigned significand multiplier with a registered 48-bit product.
module fmul_mant_mul (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] a_i,
   input  logic [23:0] b_i,
   output logic [47:0] p_o
);

   logic [47:0] p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= 48'(a_i) * 48'(b_i);
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/fmul.sv
// Three-stage binary32 multiplier: capture, significand product, normalise/round/pack.
module fmul
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s
);

   float_t      a_q, b_q;
   spec_t       spec_d, spec_q;
   logic        sign_q;
   logic [9:0]  exp_d, exp_q;
   logic [47:0] prod;
   logic [31:0] s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a;
         b_q <= b;
      end
   end

   // Denormal inputs count as zero, so a zero exponent alone marks a zero operand.
   always_comb begin
      logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      a_zero = (a_q.exp == '0);
      b_zero = (b_q.exp == '0);
      a_inf  = (a_q.exp == EXP_MAX) && (a_q.frac == '0);
      b_inf  = (b_q.exp == EXP_MAX) && (b_q.frac == '0);
      a_nan  = (a_q.exp == EXP_MAX) && (a_q.frac != '0);
      b_nan  = (b_q.exp == EXP_MAX) && (b_q.frac != '0);
      spec_d.nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      spec_d.inf  = a_inf || b_inf;
      spec_d.zero = a_zero || b_zero;
      exp_d = {2'b00, a_q.exp} + {2'b00, b_q.exp} - 10'(EXP_BIAS);
   end

   fmul_mant_mul u_mant_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   ({1'b1, a_q.frac}),
      .b_i   ({1'b1, b_q.frac}),
      .p_o   (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spec_q <= '0;
         sign_q <= 1'b0;
         exp_q  <= '0;
      end else begin
         spec_q <= spec_d;
         sign_q <= a_q.sign ^ b_q.sign;
         exp_q  <= exp_d;
      end
   end

   logic        norm, guard, sticky, round_up, unf, ovf;
   logic [22:0] mant;
   logic [23:0] mant_r;
   logic [9:0]  exp_n;
   float_t      res;

   always_comb begin
      norm     = prod[47];
      mant     = norm ? prod[46:24] : prod[45:23];
      guard    = norm ? prod[23] : prod[22];
      sticky   = norm ? (|prod[22:0]) : (|prod[21:0]);
      round_up = guard && (sticky || mant[0]);
      // A carry out of the rounded fraction leaves it all-zero, so only the exponent moves.
      mant_r   = {1'b0, mant} + 24'(round_up);
      exp_n    = exp_q + 10'(norm) + 10'(mant_r[23]);
      unf      = ($signed(exp_n) <= 10'sd0);
      ovf      = ($signed(exp_n) >= 10'sd255);
      res      = '0;
      res.sign = sign_q;
      if (spec_q.nan) begin
         res = QNAN;
      end else if (spec_q.inf) begin
         res.exp = EXP_MAX;
      end else if (!spec_q.zero && !unf) begin
         if (ovf) begin
            res.exp = EXP_MAX;
         end else begin
            res.exp  = exp_n[7:0];
            res.frac = mant_r[22:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
      end else begin
         s_q <= res;
      end
   end

   assign s = s_q;

endmodule

// File: tb/tb_fmul.sv
// Scoreboard bench for fmul: directed vectors plus a random stream against an integer model.
module tb_fmul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] s;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] expv;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   fmul dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .s     (s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: s=%08h expected %08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic [7:0]  ex, ey;
      logic [22:0] fx, fy;
      logic        sg, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
      longint unsigned p, q, r, half;
      int e, sh;
      ex = x[30:23]; ey = y[30:23];
      fx = x[22:0];  fy = y[22:0];
      sg = x[31] ^ y[31];
      x_nan  = (ex == 8'hFF) && (fx != 0);
      y_nan  = (ey == 8'hFF) && (fy != 0);
      x_inf  = (ex == 8'hFF) && (fx == 0);
      y_inf  = (ey == 8'hFF) && (fy == 0);
      x_zero = (ex == 8'h00);
      y_zero = (ey == 8'h00);
      if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) return 32'h7FC0_0000;
      if (x_inf || y_inf) return {sg, 8'hFF, 23'h0};
      if (x_zero || y_zero) return {sg, 31'h0};
      p  = longint'({1'b1, fx}) * longint'({1'b1, fy});
      e  = int'(ex) + int'(ey) - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e++;
      end
      q    = p >> sh;
      r    = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e <= 0) return {sg, 31'h0};
      if (e >= 255) return {sg, 8'hFF, 23'h0};
      return {sg, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] v;
      int unsigned sel;
      v   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) v[30:23] = 8'hFF;
      else if (sel == 1) v[30:23] = 8'h00;
      else if (sel < 12) v[30:23] = 8'($urandom_range(64, 190));
      return v;
   endfunction

   task automatic push(input logic [31:0] expv, input int due, input string name);
      exp_t e;
      e.expv = expv;
      e.due  = due;
      e.name = name;
      sb.push_back(e);
   endtask

   // Called on a falling edge: operands are captured at the next rising edge.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv,
                        input string name);
      a = x;
      b = y;
      push(expv, cyc + 3, name);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.due < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s: missed check, due cycle %0d now %0d", mon_e.name, mon_e.due, cyc);
         end else begin
            check(mon_e.name, s, mon_e.expv);
         end
      end
   end

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
      string       name;
   } vec_t;

   vec_t dirs[$];

   initial begin
      logic [31:0] x, y;
      dirs = '{
         '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "basic_1p5x2"},
         '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, "basic_neg"},
         '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "round_sq_ulp"},
         '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, "round_norm_shift"},
         '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, "tie_odd_up"},
         '{32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, "tie_even_hold"},
         '{32'h3FA1_E58F, 32'h3FCA_6691, 32'h4000_0000, "round_carry_out"},
         '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "overflow"},
         '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow_flush"},
         '{32'h8080_0000, 32'h3E80_0000, 32'h8000_0000, "underflow_neg"},
         '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, "zero_x_inf"},
         '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in"},
         '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "neg_inf"},
         '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, "denorm_in"},
         '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "neg_zero"},
         '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, "inf_x_neg"}
      };

      repeat (3) begin
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         check("reset_hold", s, 32'h0);
      end

      @(negedge clk);
      rst_n = 1'b1;
      push(32'h0, cyc + 1, "post_reset_zero_1");
      push(32'h0, cyc + 2, "post_reset_zero_2");
      issue(dirs[0].x, dirs[0].y, dirs[0].r, dirs[0].name);
      for (int i = 1; i < dirs.size(); i++) begin
         @(negedge clk);
         issue(dirs[i].x, dirs[i].y, dirs[i].r, dirs[i].name);
      end

      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         x = rnd_op();
         y = rnd_op();
         issue(x, y, ref_mul(x, y), "stream");
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: timeout, no output checked for due cycle %0d", mon_e.name, mon_e.due);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
